// File: rtl/pe_rr_scheduler.sv
// pe_rr_scheduler: round-robin owner of one shared rd/act/done datapath.
// Define SCHED_TIMEOUT_EN for the act-phase watchdog and timeout pulse.
module pe_rr_scheduler #(
  parameter int N_REQ = 4,
  parameter int RD_CYCLES = 2,
`ifdef SCHED_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES = 256,
`endif
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] owner,
  output logic             rd,
  output logic             act,
  output logic             busy,
  output logic [N_REQ-1:0] ack
`ifdef SCHED_TIMEOUT_EN
  ,
  output logic             timeout
`endif
);

  localparam int RC_W = $clog2(RD_CYCLES + 1);
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_ACT  = 2'd2;
  localparam logic [1:0] S_ACK  = 2'd3;

  logic [1:0]       state;
  logic [RC_W-1:0]  rd_cnt;
  logic [IDX_W-1:0] last_owner;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] cand;
  logic             found;
  logic             limit;
  int               idx;

  // Scan starts just past the previous owner so every requester gets a turn.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    idx    = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx  = (int'(last_owner) + i) % N_REQ;
      cand = IDX_W'(idx);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

`ifdef SCHED_TIMEOUT_EN
  localparam int AC_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [AC_W-1:0] act_cnt;

  assign limit = (act_cnt == AC_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      act_cnt <= '0;
      timeout <= 1'b0;
    end else if (en) begin
      if (state != S_ACT) act_cnt <= '0;
      else                act_cnt <= act_cnt + 1'b1;
      timeout <= (state == S_ACT) && limit && !done;
    end
  end
`else
  assign limit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      grant      <= '0;
      owner      <= '0;
      rd         <= 1'b0;
      act        <= 1'b0;
      busy       <= 1'b0;
      ack        <= '0;
      rd_cnt     <= '0;
      last_owner <= IDX_W'(N_REQ - 1);
    end else if (en) begin
      case (state)
        S_IDLE: begin
          if (found) begin
            grant  <= ONE << winner;
            owner  <= winner;
            rd     <= 1'b1;
            busy   <= 1'b1;
            rd_cnt <= RC_W'(RD_CYCLES - 1);
            state  <= S_RD;
          end
        end
        S_RD: begin
          if (done) begin
            rd    <= 1'b0;
            ack   <= ONE << owner;
            state <= S_ACK;
          end else if (rd_cnt == '0) begin
            rd    <= 1'b0;
            act   <= 1'b1;
            state <= S_ACT;
          end else begin
            rd_cnt <= rd_cnt - 1'b1;
          end
        end
        S_ACT: begin
          if (done || limit) begin
            act   <= 1'b0;
            ack   <= ONE << owner;
            state <= S_ACK;
          end
        end
        default: begin
          last_owner <= owner;
          grant      <= '0;
          ack        <= '0;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

  a_rd_act: assert property (
    @(posedge clk) disable iff (!rst_n) !(rd && act));
  a_grant: assert property (
    @(posedge clk) disable iff (!rst_n) $onehot0(grant));
  a_ack: assert property (
    @(posedge clk) disable iff (!rst_n) $onehot0(ack));

endmodule

// File: tb/tb_pe_rr_scheduler.sv
// tb_pe_rr_scheduler: directed and random transactions checked
// against a transaction-level model of the round-robin scheduler.
module tb_pe_rr_scheduler;
  localparam int N   = 4;
  localparam int RDC = 2;
`ifdef SCHED_TIMEOUT_EN
  localparam int TO  = 8;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         done;
  logic [N-1:0] req;
  logic [N-1:0] grant;
  logic [N-1:0] ack;
  logic [1:0]   owner;
  logic         rd;
  logic         act;
  logic         busy;
`ifdef SCHED_TIMEOUT_EN
  logic         timeout;
`endif

  int tests = 0;
  int fails = 0;
  int m_last;
  int m_owner;

  pe_rr_scheduler #(
    .N_REQ(N),
    .RD_CYCLES(RDC)
`ifdef SCHED_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(TO)
`endif
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .req(req),
    .done(done),
    .grant(grant),
    .owner(owner),
    .rd(rd),
    .act(act),
    .busy(busy),
    .ack(ack)
`ifdef SCHED_TIMEOUT_EN
    ,
    .timeout(timeout)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // First requester after `last`, wrapping; -1 if nobody asks.
  function automatic int arb(input int last, input logic [N-1:0] r);
    logic [N-1:0] s;
    for (int k = 1; k <= N; k++) begin
      s = r >> ((last + k) % N);
      if (s[0]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] oh(input int w);
    logic [N-1:0] one;
    one = 1;
    return one << w;
  endfunction

  task automatic chk_idle(input string tag, input int own);
    chk({tag, ".grant"}, 32'(grant), 0);
    chk({tag, ".owner"}, 32'(owner), 32'(own));
    chk({tag, ".rd"}, 32'(rd), 0);
    chk({tag, ".act"}, 32'(act), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".ack"}, 32'(ack), 0);
`ifdef SCHED_TIMEOUT_EN
    chk({tag, ".timeout"}, 32'(timeout), 0);
`endif
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    en    = 1'b1;
    done  = 1'b0;
    req   = '0;
    @(posedge clk);
    #1;
    chk_idle("reset", 0);
    rst_n   = 1'b1;
    m_last  = N - 1;
    m_owner = 0;
  endtask

  // Transaction-relative view: t counts enabled edges since IDLE.
  // Cycles 1..de are RD (first RDC) then ACT, de+1 acks, de+2 idles.
  task automatic txn(input logic [N-1:0] rv, input int d,
                     input int hold_at);
    int w;
    int t;
    int de;
    int guard;
    int holds;
    bit to_exp;
    string tg;
    w      = arb(m_last, rv);
    de     = d;
    to_exp = 1'b0;
`ifdef SCHED_TIMEOUT_EN
    if (d > RDC + TO) begin
      de     = RDC + TO;
      to_exp = 1'b1;
    end
`endif
    t     = 0;
    guard = 0;
    holds = 0;
    while (t < de + 2 && guard < 400) begin
      guard++;
      if (t == hold_at && holds < 5) begin
        en   = 1'b0;
        done = 1'b1;
        holds++;
      end else begin
        en = ($urandom_range(0, 5) != 0);
        if (!en)
          done = 1'($urandom_range(0, 1));
        else if (t == de && !to_exp)
          done = 1'b1;
        else if (t == 0 || t == de + 1)
          done = 1'($urandom_range(0, 1));
        else
          done = 1'b0;
      end
      req = (t == 0) ? rv : N'($urandom_range(0, 15));
      @(posedge clk);
      if (en) t++;
      #1;
      tg = $sformatf("w%0d.t%0d", w, t);
      if (t == 0) begin
        chk_idle(tg, m_owner);
      end else if (t == de + 2) begin
        chk_idle(tg, w);
      end else begin
        chk({tg, ".grant"}, 32'(grant), 32'(oh(w)));
        chk({tg, ".owner"}, 32'(owner), 32'(w));
        chk({tg, ".busy"}, 32'(busy), 1);
        chk({tg, ".ack"}, 32'(ack),
            (t == de + 1) ? 32'(oh(w)) : 0);
        chk({tg, ".rd"}, 32'(rd),
            32'(t <= de && t <= RDC));
        chk({tg, ".act"}, 32'(act),
            32'(t <= de && t > RDC));
`ifdef SCHED_TIMEOUT_EN
        chk({tg, ".timeout"}, 32'(timeout),
            32'(t == de + 1 && to_exp));
`endif
      end
    end
    if (guard >= 400) begin
      tests++;
      fails++;
      $error("FAIL budget t=%0d exp=%0d", t, de + 2);
    end
    m_last  = w;
    m_owner = w;
  endtask

  // Reset lands while the owner is in its act phase: no ack, fresh start.
  task automatic abort_txn(input logic [N-1:0] rv);
    int w;
    w    = arb(m_last, rv);
    req  = rv;
    en   = 1'b1;
    done = 1'b0;
    repeat (RDC + 1) @(posedge clk);
    #1;
    chk("abort.act", 32'(act), 1);
    chk("abort.owner", 32'(owner), 32'(w));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_idle("abort", 0);
    rst_n   = 1'b1;
    m_last  = N - 1;
    m_owner = 0;
  endtask

  initial begin
    int rv;
    int d;
    reset_dut();
    txn(4'b0001, RDC + 3, -1);
    reset_dut();
    repeat (5) txn(4'b1111, RDC + 1, -1);
    txn(4'b0100, 3, -1);
    txn(4'b0101, 3, -1);
    txn(4'b0101, 3, -1);
    txn(4'b1010, 1, -1);
    txn(4'b0110, RDC + 4, RDC + 1);
    abort_txn(4'b1100);
    txn(4'b1111, 3, -1);
`ifdef SCHED_TIMEOUT_EN
    txn(4'b0010, RDC + TO + 5, -1);
    txn(4'b0010, RDC + TO, -1);
`endif
    for (int n = 0; n < 40; n++) begin
      rv = $urandom_range(1, 15);
`ifdef SCHED_TIMEOUT_EN
      d = $urandom_range(1, RDC + TO + 4);
`else
      d = $urandom_range(1, 12);
`endif
      txn(N'(rv), d, -1);
    end
    req = '0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
